// File: rtl/dmem_mmio_responder.sv
// Data-port responder: word RAM plus console FIFO and timer MMIO.
// Combinational reads, writes on the rising edge, never stalls.
module dmem_mmio_responder #(
   parameter int DEPTH      = 1024,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [31:0] RAM_TOP = 32'(DEPTH * 4);

   logic [31:0] mem_q [DEPTH];
   logic [7:0]  fifo_q [FIFO_DEPTH];

   logic [PW:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0] rd_ptr_q, rd_ptr_d;
   logic        ovf_q, ovf_d;
   logic [31:0] count_q, count_d;
   logic [31:0] cmp_q, cmp_d;
   logic        irq_q, irq_d;

   logic [29:0] wa;
   logic        is_ram, is_cdata, is_cstat, is_timer, is_cmp;
   logic        empty, full, push, pop;

   assign wa       = ALUResult[31:2];
   assign is_ram   = ALUResult < RAM_TOP;
   assign is_cdata = wa == 30'h0400_0000;
   assign is_cstat = wa == 30'h0400_0001;
   assign is_timer = wa == 30'h0400_0002;
   assign is_cmp   = wa == 30'h0400_0003;

   // Extra pointer bit distinguishes full from empty.
   assign empty = wr_ptr_q == rd_ptr_q;
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                  (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign push  = MemWrite && is_cdata && !full;
   assign pop   = !empty && tx_ready;

   assign tx_valid  = !empty;
   assign tx_data   = empty ? 8'h00 : fifo_q[rd_ptr_q[PW-1:0]];
   assign timer_irq = irq_q;

   always_comb begin
      ReadData = '0;
      unique case (1'b1)
         is_ram:   ReadData = mem_q[wa[AW-1:0]];
         is_cstat: ReadData = {29'b0, ovf_q, full, empty};
         is_timer: ReadData = count_q;
         is_cmp:   ReadData = cmp_q;
         default:  ReadData = '0;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      ovf_d    = ovf_q;
      if (MemWrite && is_cstat)
         ovf_d = 1'b0;
      else if (MemWrite && is_cdata && full)
         ovf_d = 1'b1;
      count_d = (MemWrite && is_timer) ? WriteData : count_q + 32'd1;
      cmp_d   = (MemWrite && is_cmp) ? WriteData : cmp_q;
      irq_d   = irq_q;
      if (MemWrite && is_cmp)
         irq_d = 1'b0;
      else if (count_q == cmp_q)
         irq_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         count_q  <= '0;
         cmp_q    <= 32'hFFFF_FFFF;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         count_q  <= count_d;
         cmp_q    <= cmp_d;
         irq_q    <= irq_d;
      end
   end

   // Storage arrays carry no reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (MemWrite && is_ram)
         mem_q[wa[AW-1:0]] <= WriteData;
      if (reset && push)
         fifo_q[wr_ptr_q[PW-1:0]] <= WriteData[7:0];
   end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: directed loads, console
// stream and timer vectors, checked by a negedge monitor.
module tb_dmem_mmio_responder;

   localparam logic [31:0] CDATA = 32'h1000_0000;
   localparam logic [31:0] CSTAT = 32'h1000_0004;
   localparam logic [31:0] TIMER = 32'h1000_0008;
   localparam logic [31:0] TCMP  = 32'h1000_000C;
   localparam logic [31:0] UNMAP = 32'h2000_0000;

   localparam int S_RD   = 0;
   localparam int S_VAL  = 1;
   localparam int S_IRQ  = 2;
   localparam int S_DATA = 3;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } chk_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] ALUResult = UNMAP;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        timer_irq;

   logic        probe = 1'b0;
   chk_t        chkq[$];
   logic [7:0]  txq[$];
   int          n_vec = 0;
   int          n_miss = 0;

   dmem_mmio_responder #(.DEPTH(1024), .FIFO_DEPTH(8)) dut (
      .clk(clk),
      .reset(reset),
      .MemWrite(MemWrite),
      .ALUResult(ALUResult),
      .WriteData(WriteData),
      .ReadData(ReadData),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (probe) begin
         chk_t c;
         logic [31:0] act;
         n_vec++;
         if (chkq.size() == 0) begin
            n_miss++;
            $display("FAIL probe: no expectation queued");
         end else begin
            c = chkq.pop_front();
            act = '0;
            case (c.sel)
               S_RD:    act = ReadData;
               S_VAL:   act = {31'b0, tx_valid};
               S_IRQ:   act = {31'b0, timer_irq};
               default: act = {24'b0, tx_data};
            endcase
            if (act !== c.exp) begin
               n_miss++;
               $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
         end
      end
      if (reset && tx_valid && tx_ready) begin
         n_vec++;
         if (txq.size() == 0) begin
            n_miss++;
            $display("FAIL tx: unexpected byte %h", tx_data);
         end else begin
            logic [7:0] e;
            e = txq.pop_front();
            if (tx_data !== e) begin
               n_miss++;
               $display("FAIL tx: got %h expected %h", tx_data, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      probe = 1'b0;
      ALUResult = UNMAP;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      MemWrite = 1'b1;
      ALUResult = a;
      WriteData = d;
      tick();
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e,
                     input string nm);
      chk_t c;
      c.sel = S_RD;
      c.exp = e;
      c.name = nm;
      chkq.push_back(c);
      ALUResult = a;
      probe = 1'b1;
      tick();
   endtask

   task automatic chk(input int s, input logic [31:0] e, input string nm);
      chk_t c;
      c.sel = s;
      c.exp = e;
      c.name = nm;
      chkq.push_back(c);
      probe = 1'b1;
      tick();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      rd(TIMER, 32'h0, "rst_timer");
      rd(TCMP, 32'hFFFF_FFFF, "rst_cmp");
      rd(CSTAT, 32'h1, "rst_stat");
      chk(S_VAL, 0, "rst_valid");
      chk(S_DATA, 0, "rst_txdata");
      chk(S_IRQ, 0, "rst_irq");

      wr(32'h10, 32'hDEAD_BEEF);
      rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
      wr(32'hFFC, 32'h1234_5678);
      rd(32'hFFC, 32'h1234_5678, "ram_top");
      rd(32'h1000, 32'h0, "ram_edge_unmapped");
      rd(UNMAP, 32'h0, "unmapped");
      wr(UNMAP, 32'hFFFF_FFFF);
      rd(UNMAP, 32'h0, "unmapped_wr");
      rd(CDATA, 32'h0, "cdata_rd");

      for (int i = 0; i < 8; i++)
         wr(CDATA, 32'h41 + i);
      rd(CSTAT, 32'h2, "stat_full");
      wr(CDATA, 32'h49);
      rd(CSTAT, 32'h6, "stat_ovf");
      chk(S_DATA, 32'h41, "head_stable");
      for (int i = 0; i < 8; i++)
         txq.push_back(8'(8'h41 + i));
      tx_ready = 1'b1;
      repeat (9) tick();
      chk(S_VAL, 0, "drained");
      rd(CSTAT, 32'h5, "stat_empty_ovf");
      wr(CSTAT, 32'h0);
      rd(CSTAT, 32'h1, "stat_clr");

      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr(CDATA, 32'h50 + i);
         txq.push_back(8'(8'h50 + i));
      end
      tx_ready = 1'b1;
      wr(CDATA, 32'h58);
      tx_ready = 1'b0;
      rd(CSTAT, 32'h4, "full_pushpop_drop");
      wr(CSTAT, 32'h0);
      tx_ready = 1'b1;
      repeat (8) tick();
      chk(S_VAL, 0, "drained2");
      tx_ready = 1'b0;

      for (int i = 0; i < 3; i++)
         wr(CDATA, 32'h61 + i);
      for (int i = 0; i < 4; i++)
         txq.push_back(8'(8'h61 + i));
      tx_ready = 1'b1;
      wr(CDATA, 32'h64);
      tx_ready = 1'b0;
      rd(CSTAT, 32'h0, "occ3_stat");
      chk(S_DATA, 32'h62, "occ3_head");
      tx_ready = 1'b1;
      tick();
      tick();
      chk(S_VAL, 1, "occ3_last");
      chk(S_VAL, 0, "occ3_empty");
      tx_ready = 1'b0;

      wr(TIMER, 32'hFFFF_FFFE);
      rd(TIMER, 32'hFFFF_FFFE, "tmr_v");
      rd(TIMER, 32'hFFFF_FFFF, "tmr_v1");
      rd(TIMER, 32'h0, "tmr_wrap");

      wr(TCMP, 32'd20);
      wr(TIMER, 32'd0);
      repeat (20) tick();
      chk(S_IRQ, 0, "irq_pre");
      chk(S_IRQ, 1, "irq_rise");
      repeat (5) tick();
      chk(S_IRQ, 1, "irq_hold");
      wr(TCMP, 32'hFFFF_0000);
      chk(S_IRQ, 0, "irq_clr");

      for (int i = 0; i < 3; i++)
         wr(CDATA, 32'h71 + i);
      txq.push_back(8'h71);
      tx_ready = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      rd(TIMER, 32'h0, "rst2_timer");
      chk(S_IRQ, 0, "rst2_irq");
      chk(S_VAL, 0, "rst2_valid");
      repeat (4) tick();
      tx_ready = 1'b0;

      n_vec++;
      if (txq.size() != 0) begin
         n_miss++;
         $display("FAIL tx_left: got %0d bytes outstanding expected 0",
                  txq.size());
      end
      n_vec++;
      if (chkq.size() != 0) begin
         n_miss++;
         $display("FAIL chk_left: got %0d probes outstanding expected 0",
                  chkq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
